// File: rtl/instr_encoder.sv
// Field-level MIPS instruction encoder feeding a small FIFO.
// Each accepted request is assembled into a 32-bit word. The word is
// tagged with its program counter and queued for the instruction-memory
// loader. An illegal op still completes the handshake. It produces no word
// and sets a sticky error flag instead.
module instr_encoder #(
    parameter int          DEPTH   = 4,
    parameter logic [31:0] PC_BASE = 32'h0000_3000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_op,
    input  logic [4:0]               in_rs,
    input  logic [4:0]               in_rt,
    input  logic [4:0]               in_rd,
    input  logic [15:0]              in_imm,
    input  logic [25:0]              in_tgt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDU = 4'd1;
    localparam logic [3:0] OP_SUBU = 4'd2;
    localparam logic [3:0] OP_ORI  = 4'd3;
    localparam logic [3:0] OP_LUI  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SW   = 4'd6;
    localparam logic [3:0] OP_BEQ  = 4'd7;
    localparam logic [3:0] OP_JAL  = 4'd8;
    localparam logic [3:0] OP_JR   = 4'd9;

    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_next_pc;
    logic          r_err;

    logic [31:0]   w_word;
    logic          w_legal;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;

    // Assemble the instruction word; fields an op does not use stay zero.
    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b1;
        case (in_op)
            OP_NOP:  w_word = 32'h0000_0000;
            OP_ADDU: w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100001};
            OP_SUBU: w_word = {6'b000000, in_rs, in_rt, in_rd, 5'b00000, 6'b100011};
            OP_ORI:  w_word = {6'b001101, in_rs, in_rt, in_imm};
            OP_LUI:  w_word = {6'b001111, 5'b00000, in_rt, in_imm};
            OP_LW:   w_word = {6'b100011, in_rs, in_rt, in_imm};
            OP_SW:   w_word = {6'b101011, in_rs, in_rt, in_imm};
            OP_BEQ:  w_word = {6'b000100, in_rs, in_rt, in_imm};
            OP_JAL:  w_word = {6'b000011, in_tgt};
            OP_JR:   w_word = {6'b000000, in_rs, 15'b0, 6'b001000};
            default: w_legal = 1'b0;
        endcase
    end

    // A full FIFO can still take a request on the cycle its head leaves.
    assign w_pop    = out_valid && out_ready;
    assign in_ready = (r_count < FULL) || w_pop;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;

    assign out_valid = (r_count != '0);
    assign out_instr = r_instr[r_rptr];
    assign out_pc    = r_pc[r_rptr];
    assign count     = r_count;
    assign err       = r_err;

    // FIFO storage: write the tail on a legal accept; clr restores reset contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= 32'h0000_0000;
                r_pc[i]    <= PC_BASE;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= 32'h0000_0000;
                r_pc[i]    <= PC_BASE;
            end
        end else if (w_push) begin
            r_instr[r_wptr] <= w_word;
            r_pc[r_wptr]    <= r_next_pc;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Next PC advances only on legal words; an illegal op latches the error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_next_pc <= PC_BASE;
            r_err     <= 1'b0;
        end else if (clr) begin
            r_next_pc <= PC_BASE;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) r_next_pc <= r_next_pc + 32'd4;
            else         r_err     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: a reference model fills a scoreboard, and a
// monitor checks the FIFO head and the status outputs against it.
module tb_instr_encoder;

    localparam int          DEPTH   = 4;
    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_BASE = 32'h0000_3000;

    logic          clk, reset, clr, in_valid, in_ready, out_valid, out_ready, err;
    logic [3:0]    in_op;
    logic [4:0]    in_rs, in_rt, in_rd;
    logic [15:0]   in_imm;
    logic [25:0]   in_tgt;
    logic [31:0]   out_instr, out_pc;
    logic [CW-1:0] count;

    instr_encoder #(.DEPTH(DEPTH), .PC_BASE(PC_BASE)) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_imm(in_imm), .in_tgt(in_tgt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .count(count), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int          m_cnt = 0;
    logic [31:0] m_pc  = PC_BASE;
    bit          m_err = 0;
    bit          m_pop, m_rdy;
    bit          rnd_rdy = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference encoding built from the MIPS field positions with plain arithmetic.
    function automatic logic [31:0] enc(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] s, t, d, i;
        s = 32'(rs) << 21;
        t = 32'(rt) << 16;
        d = 32'(rd) << 11;
        i = 32'(imm);
        case (op)
            4'd1:    return s + t + d + 32'd33;
            4'd2:    return s + t + d + 32'd35;
            4'd3:    return (32'd13 << 26) + s + t + i;
            4'd4:    return (32'd15 << 26) + t + i;
            4'd5:    return (32'd35 << 26) + s + t + i;
            4'd6:    return (32'd43 << 26) + s + t + i;
            4'd7:    return (32'd4 << 26) + s + t + i;
            4'd8:    return (32'd3 << 26) + 32'(tgt);
            4'd9:    return s + 32'd8;
            default: return 32'd0;
        endcase
    endfunction

    // Reference model: decides acceptance from its own occupancy and queues expected words.
    always @(posedge clk or negedge reset) begin
        if (!reset || clr) begin
            sb.delete();
            m_cnt = 0;
            m_pc  = PC_BASE;
            m_err = 0;
        end else begin
            m_pop = (m_cnt > 0) && out_ready;
            m_rdy = (m_cnt < DEPTH) || m_pop;
            if (in_valid && m_rdy) begin
                if (in_op <= 4'd9) begin
                    sb.push_back('{enc(in_op, in_rs, in_rt, in_rd, in_imm, in_tgt), m_pc});
                    m_pc = m_pc + 32'd4;
                    m_cnt++;
                end else begin
                    m_err = 1;
                end
            end
            if (m_pop) m_cnt--;
        end
    end

    // Monitor: compares status and FIFO head mid-cycle, pops the scoreboard on a handshake.
    always @(negedge clk) begin
        if (reset) begin
            chk("count", 32'(count), 32'(m_cnt));
            chk("out_valid", 32'(out_valid), 32'(m_cnt > 0));
            chk("in_ready", 32'(in_ready), 32'((m_cnt < DEPTH) || (m_cnt > 0 && out_ready)));
            chk("err", 32'(err), 32'(m_err));
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL head_unexpected: got word %h with empty scoreboard", out_instr);
                end else begin
                    chk("head_instr", out_instr, sb[0].instr);
                    chk("head_pc", out_pc, sb[0].pc);
                    if (out_ready && !clr) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt);
        int n;
        bit acc;
        n   = 0;
        acc = 0;
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm; in_tgt = tgt;
        in_valid = 1'b1;
        while (!acc && n < 64) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: op %0d not accepted, got in_ready=0 expected 1 within 64 cycles", op);
        end
    endtask

    task automatic pulse_clr(input bit with_req);
        clr = 1'b1;
        if (with_req) begin
            in_op = 4'd1; in_rs = 5'd9; in_rt = 5'd8; in_rd = 5'd7;
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_tgt = '0;
        #2 reset = 1'b0;
        #2;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'h0000_0000);
        chk("rst_out_pc", out_pc, PC_BASE);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;

        // ori with no bypass: visible the cycle after acceptance
        send(4'd3, 5'd0, 5'd1, 5'd0, 16'h1234, 26'd0);
        chk("ori_valid", 32'(out_valid), 32'd1);
        chk("ori_instr", out_instr, 32'h3401_1234);
        chk("ori_pc", out_pc, 32'h0000_3000);
        drain();

        // addu then jal streamed straight through
        pulse_clr(0);
        out_ready = 1'b1;
        send(4'd1, 5'd1, 5'd2, 5'd3, 16'hABCD, 26'h3FF_FFFF);
        send(4'd8, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h000_0C03);
        drain();

        // unused fields must be zeroed
        pulse_clr(0);
        send(4'd4, 5'd5, 5'd4, 5'd9, 16'hFFFF, 26'h155_5555);
        chk("lui_instr", out_instr, 32'h3C04_FFFF);
        send(4'd9, 5'd31, 5'd3, 5'd7, 16'hFFFF, 26'h3FF_FFFF);
        drain();

        // fill to DEPTH, then push while popping
        pulse_clr(0);
        for (int k = 0; k < DEPTH; k++) send(4'(1 + k), 5'(k), 5'(k + 1), 5'(k + 2), 16'(k * 3), 26'(k));
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'h0010, 26'd0);
        chk("full_pushpop_count", 32'(count), 32'(DEPTH));
        drain();

        // illegal op: consumed, no word, sticky err
        pulse_clr(0);
        send(4'd12, 5'd3, 5'd4, 5'd5, 16'h7777, 26'h123_4567);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(count), 32'd0);
        send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'd0);
        chk("beq_instr", out_instr, 32'h1022_FFFE);
        chk("beq_pc", out_pc, 32'h0000_3000);
        chk("err_sticky", 32'(err), 32'd1);

        // clr with three words buffered and a request pending
        send(4'd5, 5'd2, 5'd3, 5'd0, 16'h0004, 26'd0);
        send(4'd6, 5'd2, 5'd3, 5'd0, 16'h0008, 26'd0);
        pulse_clr(1);
        chk("clr_count", 32'(count), 32'd0);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        send(4'd2, 5'd4, 5'd5, 5'd6, 16'd0, 26'd0);
        chk("clr_next_pc", out_pc, 32'h0000_3000);

        // asynchronous reset in the middle of a cycle
        send(4'd3, 5'd1, 5'd1, 5'd0, 16'h00FF, 26'd0);
        send(4'd0, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'h3FF_FFFF);
        #2 reset = 1'b0;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        send(4'd6, 5'd29, 5'd31, 5'd0, 16'hFFF8, 26'd0);
        chk("arst_sw_instr", out_instr, 32'hAFBF_FFF8);
        chk("arst_next_pc", out_pc, 32'h0000_3000);
        drain();

        // randomized traffic with random back-pressure
        rnd_rdy = 1;
        for (int k = 0; k < 300; k++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 7) == 0) ? 4'(10 + $urandom_range(0, 5)) : 4'($urandom_range(0, 9));
            if ($urandom_range(0, 39) == 0) pulse_clr(1'($urandom_range(0, 1)));
            send(op, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_rdy = 0;
        #1;
        drain();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);
        chk("final_count", 32'(count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Encoder counterpart to the per-stage instruction decoders. It accepts field-level instruction requests (operation select plus register, immediate and target fields) over a valid/ready handshake. It assembles each request into a 32-bit MIPS word, buffers the words in a small FIFO, and streams them with their PC to the instruction-memory loader. Used by the program-loading path and by bench stimulus generators for the pipelined CPU.

Parameters:
DEPTH, 4, FIFO entries; power of two, 2..16.
PC_BASE, 32'h0000_3000, PC of the first word after reset or clear.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
clr  input  1  synchronous clear: empties FIFO, reloads PC, clears err.
in_valid  input  1  request valid.
in_ready  output  1  request accepted when in_valid && in_ready.
in_op  input  4  operation: 0 nop, 1 addu, 2 subu, 3 ori, 4 lui, 5 lw, 6 sw, 7 beq, 8 jal, 9 jr; 10..15 illegal.
in_rs  input  5  rs field.
in_rt  input  5  rt field.
in_rd  input  5  rd field.
in_imm  input  16  immediate / offset.
in_tgt  input  26  jal target field.
out_valid  output  1  FIFO head valid.
out_ready  input  1  consumer accepts head when out_valid && out_ready.
out_instr  output  32  encoded word at FIFO head.
out_pc  output  32  PC assigned to head word.
count  output  log2(DEPTH)+1  current FIFO occupancy.
err  output  1  sticky illegal-op flag.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO empty; count=0; out_valid=0.
  - out_instr=0; out_pc=PC_BASE; err=0; in_ready=1.
  - Internal next-PC register = PC_BASE.
- Encoding (combinational from inputs; registered into FIFO on accept):
  - nop: 32'h0000_0000.
  - addu: {6'b000000, rs, rt, rd, 5'b0, 6'b100001}.
  - subu: same as addu with funct 6'b100011.
  - jr: {6'b000000, rs, 15'b0, 6'b001000}.
  - ori: {6'b001101, rs, rt, imm}.
  - lui: {6'b001111, 5'b0, rt, imm}; in_rs ignored.
  - lw: {6'b100011, rs, rt, imm}.
  - sw: {6'b101011, rs, rt, imm}.
  - beq: {6'b000100, rs, rt, imm}.
  - jal: {6'b000011, tgt}.
  - Unused fields are forced to zero regardless of input values.
- Illegal op (in_op 10..15) on accept:
  - Handshake completes; nothing is written to the FIFO.
  - PC does not advance; err set to 1 and held until reset or clr.
- Accept and PC assignment:
  - in_ready = (count < DEPTH) || (out_valid && out_ready). A full FIFO accepts in the same cycle the head is popped.
  - Each legal accept writes {word, next_pc} to the tail, then next_pc += 4, wrapping modulo 2^32.
- Output:
  - out_instr and out_pc come directly from FIFO head storage.
  - Latency: a word accepted at edge N shows out_valid=1 after edge N when the FIFO was empty. No bypass.
  - Head is stable while out_valid && !out_ready.
- Simultaneous push and pop: count unchanged; order preserved.
- Pointers: log2(DEPTH) bits, wrap naturally. Full when count==DEPTH; empty when count==0.
- clr:
  - Priority over push and pop in the same cycle; the request that cycle is dropped.
  - After the edge, state equals reset state.
- Reset mid-stream: discards all buffered words; no partial output.

Test Plan:
- Reset, then push ori rs=0 rt=1 imm=16'h1234 -> next cycle out_valid=1, out_instr=32'h3401_1234, out_pc=32'h0000_3000.
- Push addu rs=1 rt=2 rd=3, then jal tgt=26'h0000C03, with out_ready=1 -> words 32'h0022_1821 at PC 0x3000 and 32'h0C00_0C03 at PC 0x3004.
- Push lui rs=5 rt=4 imm=16'hFFFF, then jr rs=31 rd=7 -> 32'h3C04_FFFF and 32'h03E0_0008; unused fields zeroed.
- Hold out_ready=0 and push 5 requests with DEPTH=4 -> in_ready drops after 4 accepts, count=4. Assert out_ready and push simultaneously -> count stays 4, order preserved, PCs 0x3000..0x3010.
- Push in_op=12, then beq rs=1 rt=2 imm=16'hFFFE -> err=1 sticky, no word for op 12; beq word 32'h1022_FFFE at PC 0x3000.
- Fill 3 entries, then pulse clr (or drive reset low asynchronously mid-cycle) -> count=0, out_valid=0, err=0; next push gets PC 0x3000.
